// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants for the RV32I execute-stage ALU: opcode values and the
// funct3 encodings for ALU and branch operations. Imported by riscv_alu and
// alu_branch_cmp.
package alu_pkg;

  // RV32I major opcodes decoded by the ALU
  localparam logic [6:0] AL_OP     = 7'b0110011;
  localparam logic [6:0] ALI_OP    = 7'b0010011;
  localparam logic [6:0] MEM_RD_OP = 7'b0000011;
  localparam logic [6:0] MEM_WR_OP = 7'b0100011;
  localparam logic [6:0] BR_OP     = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] AUIPC     = 7'b0010111;

  // funct3 encodings for register/immediate ALU operations
  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SRL  = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_f3_e;

  // funct3 encodings for conditional branches
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

endpackage

// File: rtl/alu_branch_cmp.sv
// alu_branch_cmp
// Combinational branch condition evaluator.
// Ports:
//   rs1_i, rs2_i : operands compared
//   func3_i      : branch funct3 (beq/bne/blt/bge/bltu/bgeu)
//   taken_o      : high when the condition holds; reserved codes give 0
module alu_branch_cmp
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [2:0]       func3_i,
  output logic             taken_o
);

  logic isEqual;
  logic isLessSigned;
  logic isLessUnsigned;

  assign isEqual        = (rs1_i == rs2_i);
  assign isLessSigned   = ($signed(rs1_i) < $signed(rs2_i));
  assign isLessUnsigned = (rs1_i < rs2_i);

  // Select the condition named by funct3; 010/011 are not branches
  always_comb begin
    taken_o = 1'b0;
    case (func3_i)
      F3_BEQ:  taken_o = isEqual;
      F3_BNE:  taken_o = ~isEqual;
      F3_BLT:  taken_o = isLessSigned;
      F3_BGE:  taken_o = ~isLessSigned;
      F3_BLTU: taken_o = isLessUnsigned;
      F3_BGEU: taken_o = ~isLessUnsigned;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_alu.sv
// riscv_alu
// RV32I execute-stage ALU. Decodes opcode/func3/func7 and registers the
// result, PC+4, control-transfer target and branch decision (1-cycle latency).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rs1, rs2            : operand A, operand B / pre-extended immediate
//   pc                  : PC of the instruction
//   func3, func7, opcode: instruction fields (only func7[5] is decoded)
//   alu_result          : computed result
//   pc_plus_4           : pc + 4
//   jump_target         : branch/jump destination
//   zero                : high when the registered alu_result is 0
//   branch_taken        : control transfer taken
// Optional feature: define ALU_JAL_AUIPC_EN to decode JAL and AUIPC; without
// it those opcodes produce all-zero results like any unknown opcode.
module riscv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] pc,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [6:0]       opcode,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] pc_plus_4,
  output logic [WIDTH-1:0] jump_target,
  output logic             zero,
  output logic             branch_taken
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] pcPlus4;
  logic [WIDTH-1:0] pcPlusImm;
  logic [4:0]       shamt;
  logic             brTaken;
  logic [WIDTH-1:0] arithResult;

  logic [WIDTH-1:0] alu_result_q,   alu_result_d;
  logic [WIDTH-1:0] pc_plus_4_q,    pc_plus_4_d;
  logic [WIDTH-1:0] jump_target_q,  jump_target_d;
  logic             branch_taken_q, branch_taken_d;

  // Only func7[5] selects alternate operations; the other bits are ignored
  logic unusedFunc7;
  assign unusedFunc7 = ^{func7[6], func7[4:0]};

  assign sum       = rs1 + rs2;
  assign diff      = rs1 - rs2;
  assign pcPlus4   = pc + WIDTH'(4);
  assign pcPlusImm = pc + rs2;
  assign shamt     = rs2[4:0];

  alu_branch_cmp #(.WIDTH(WIDTH)) u_branch_cmp (
    .rs1_i   (rs1),
    .rs2_i   (rs2),
    .func3_i (func3),
    .taken_o (brTaken)
  );

  // Register/immediate ALU operations. Subtract exists only for the register
  // form: addi has no func7 field, so func7[5] is ignored there.
  always_comb begin
    arithResult = '0;
    case (func3)
      F3_ADD:  arithResult = ((opcode == AL_OP) && func7[5]) ? diff : sum;
      F3_SLL:  arithResult = rs1 << shamt;
      F3_SLT:  arithResult = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      F3_SLTU: arithResult = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
      F3_XOR:  arithResult = rs1 ^ rs2;
      F3_SRL:  arithResult = func7[5] ? WIDTH'($signed(rs1) >>> shamt) : (rs1 >> shamt);
      F3_OR:   arithResult = rs1 | rs2;
      F3_AND:  arithResult = rs1 & rs2;
      default: arithResult = '0;
    endcase
  end

  // Opcode decode into next-state values of the output registers
  always_comb begin
    alu_result_d   = '0;
    jump_target_d  = '0;
    branch_taken_d = 1'b0;
    pc_plus_4_d    = pcPlus4;
    case (opcode)
      AL_OP, ALI_OP:       alu_result_d = arithResult;
      MEM_RD_OP, MEM_WR_OP: alu_result_d = sum;
      BR_OP: begin
        alu_result_d   = diff;
        jump_target_d  = pcPlusImm;
        branch_taken_d = brTaken;
      end
      JALR: begin
        alu_result_d   = pcPlus4;
        jump_target_d  = {sum[WIDTH-1:1], 1'b0};
        branch_taken_d = 1'b1;
      end
      LUI:                 alu_result_d = rs2;
`ifdef ALU_JAL_AUIPC_EN
      JAL: begin
        alu_result_d   = pcPlus4;
        jump_target_d  = pcPlusImm;
        branch_taken_d = 1'b1;
      end
      AUIPC:               alu_result_d = pcPlusImm;
`endif
      default: begin
        alu_result_d   = '0;
        jump_target_d  = '0;
        branch_taken_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset wins over any operation presented the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q   <= '0;
      pc_plus_4_q    <= '0;
      jump_target_q  <= '0;
      branch_taken_q <= 1'b0;
    end else begin
      alu_result_q   <= alu_result_d;
      pc_plus_4_q    <= pc_plus_4_d;
      jump_target_q  <= jump_target_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign alu_result   = alu_result_q;
  assign pc_plus_4    = pc_plus_4_q;
  assign jump_target  = jump_target_q;
  assign branch_taken = branch_taken_q;
  assign zero         = (alu_result_q == '0);

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu
// Self-checking bench for riscv_alu: directed cases plus randomized
// operations compared against a behavioural model of the RV32I rules.
module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1, rs2, pc;
  logic [2:0]  func3;
  logic [6:0]  func7, opcode;
  logic [31:0] alu_result, pc_plus_4, jump_target;
  logic        zero, branch_taken;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  riscv_alu #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1          (rs1),
    .rs2          (rs2),
    .pc           (pc),
    .func3        (func3),
    .func7        (func7),
    .opcode       (opcode),
    .alu_result   (alu_result),
    .pc_plus_4    (pc_plus_4),
    .jump_target  (jump_target),
    .zero         (zero),
    .branch_taken (branch_taken)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Arithmetic right shift built from a logical shift and a sign fill mask
  function automatic logic [31:0] sraModel(input logic [31:0] a, input int sh);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
  endfunction

  // Behavioural reference from the instruction rules, using integer compares
  function automatic void refModel(
    input  logic [6:0]  op, input logic [2:0] f3, input logic [6:0] f7,
    input  logic [31:0] a,  input logic [31:0] b, input logic [31:0] p,
    output logic [31:0] res, output logic [31:0] tgt, output logic tk,
    output bit tgtDefined);
    int signed   sa, sb;
    longint      ua, ub;
    int          sh;
    sa = a; sb = b; ua = a; ub = b; sh = b[4:0];
    res = 32'h0; tgt = 32'h0; tk = 1'b0; tgtDefined = 1'b1;
    case (op)
      7'b0110011, 7'b0010011: begin
        tgtDefined = 1'b0;
        case (f3)
          3'd0: res = (op == 7'b0110011 && f7[5]) ? a - b : a + b;
          3'd1: res = a << sh;
          3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
          3'd3: res = (ua < ub) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: res = f7[5] ? sraModel(a, sh) : a >> sh;
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
      7'b0000011, 7'b0100011: begin res = a + b; tgtDefined = 1'b0; end
      7'b1100011: begin
        res = a - b;
        tgt = p + b;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = (sa < sb);
          3'd5: tk = (sa >= sb);
          3'd6: tk = (ua < ub);
          3'd7: tk = (ua >= ub);
          default: tk = 1'b0;
        endcase
      end
      7'b1100111: begin res = p + 4; tgt = (a + b) & 32'hFFFF_FFFE; tk = 1'b1; end
      7'b0110111: begin res = b; tgtDefined = 1'b0; end
`ifdef ALU_JAL_AUIPC_EN
      7'b1101111: begin res = p + 4; tgt = p + b; tk = 1'b1; end
      7'b0010111: begin res = p + b; tgtDefined = 1'b0; end
`endif
      default: ;
    endcase
  endfunction

  // Drive one operation away from the edge, then sample just after it
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] p);
    @(negedge clk);
    opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; pc = p;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the model for the inputs just applied
  task automatic checkAll(input string tag);
    logic [31:0] expRes, expTgt;
    logic        expTk;
    bit          tgtDefined;
    refModel(opcode, func3, func7, rs1, rs2, pc, expRes, expTgt, expTk, tgtDefined);
    checkOutput({tag, ".res"}, alu_result, expRes);
    checkOutput({tag, ".pc4"}, pc_plus_4, pc + 32'd4);
    checkOutput({tag, ".taken"}, {31'b0, branch_taken}, {31'b0, expTk});
    checkOutput({tag, ".zero"}, {31'b0, zero}, {31'b0, (expRes == 32'h0)});
    if (tgtDefined) checkOutput({tag, ".tgt"}, jump_target, expTgt);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".res"}, alu_result, 32'h0);
    checkOutput({tag, ".pc4"}, pc_plus_4, 32'h0);
    checkOutput({tag, ".tgt"}, jump_target, 32'h0);
    checkOutput({tag, ".taken"}, {31'b0, branch_taken}, 32'h0);
    checkOutput({tag, ".zero"}, {31'b0, zero}, 32'h1);
  endtask

  localparam logic [6:0] OPS [11] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                      7'b0100011, 7'b1100011, 7'b1100111,
                                      7'b0110111, 7'b1101111, 7'b0010111,
                                      7'h7F, 7'h00};

  initial begin
    // Reset held for two edges while a live add is presented: reset wins
    rst = 1'b1;
    opcode = 7'b0110011; func3 = 3'd0; func7 = 7'h00;
    rs1 = 32'd5; rs2 = 32'd3; pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(7'b0110011, 3'd0, 7'h00, 32'd5, 32'd3, 32'h100);
    checkAll("add");
    checkOutput("add.lit", alu_result, 32'h8);

    // Inputs unchanged: outputs hold
    @(posedge clk); #1;
    checkAll("hold");

    applyStimulus(7'b0110011, 3'd0, 7'h20, 32'd10, 32'd4, 32'h104);
    checkOutput("sub.lit", alu_result, 32'h6);
    applyStimulus(7'b0110011, 3'd4, 7'h00, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h108);
    checkOutput("xor.lit", alu_result, 32'hFFFFFFFF);
    applyStimulus(7'b0010011, 3'd0, 7'h20, 32'd5, 32'd5, 32'h10C);
    checkOutput("addi.lit", alu_result, 32'hA);
    applyStimulus(7'b0010011, 3'd2, 7'h00, 32'hFFFFFFF0, 32'd5, 32'h110);
    checkOutput("slti.lit", alu_result, 32'h1);
    applyStimulus(7'b0010011, 3'd3, 7'h00, 32'hFFFFFFF0, 32'd5, 32'h114);
    checkOutput("sltiu.lit", alu_result, 32'h0);
    applyStimulus(7'b0010011, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'h118);
    checkOutput("srai.lit", alu_result, 32'hF8000000);
    applyStimulus(7'b0010011, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'h11C);
    checkOutput("srli.lit", alu_result, 32'h08000000);

    applyStimulus(7'b1100111, 3'd0, 7'h00, 32'h2000, 32'd8, 32'h1000);
    checkOutput("jalr.res", alu_result, 32'h1004);
    checkOutput("jalr.tgt", jump_target, 32'h2008);
    checkOutput("jalr.taken", {31'b0, branch_taken}, 32'h1);
    applyStimulus(7'b1100111, 3'd0, 7'h00, 32'h2000, 32'd9, 32'h1000);
    checkOutput("jalr9.tgt", jump_target, 32'h2008);

    applyStimulus(7'b1100011, 3'd0, 7'h00, 32'd10, 32'd10, 32'h200);
    checkOutput("beq.taken", {31'b0, branch_taken}, 32'h1);
    checkOutput("beq.zero", {31'b0, zero}, 32'h1);
    checkOutput("beq.tgt", jump_target, 32'h20A);
    applyStimulus(7'b1100011, 3'd1, 7'h00, 32'd10, 32'd10, 32'h200);
    checkOutput("bne.taken", {31'b0, branch_taken}, 32'h0);
    applyStimulus(7'b1100011, 3'd4, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h200);
    checkOutput("blt.taken", {31'b0, branch_taken}, 32'h1);
    applyStimulus(7'b1100011, 3'd6, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h200);
    checkOutput("bltu.taken", {31'b0, branch_taken}, 32'h0);

    applyStimulus(7'b0110111, 3'd0, 7'h00, 32'h0, 32'h12345000, 32'h300);
    checkOutput("lui.lit", alu_result, 32'h12345000);
    applyStimulus(7'b0000011, 3'd2, 7'h00, 32'h10001000, 32'h00000FFF, 32'h304);
    checkOutput("load.lit", alu_result, 32'h10001FFF);
    applyStimulus(7'h7F, 3'd0, 7'h00, 32'h1234, 32'h5678, 32'h308);
    checkOutput("unk.res", alu_result, 32'h0);
    checkOutput("unk.tgt", jump_target, 32'h0);
    checkOutput("unk.taken", {31'b0, branch_taken}, 32'h0);
    applyStimulus(7'b1101111, 3'd0, 7'h00, 32'h1234, 32'h40, 32'h30C);
`ifndef ALU_JAL_AUIPC_EN
    checkOutput("jal_off.res", alu_result, 32'h0);
    checkOutput("jal_off.tgt", jump_target, 32'h0);
    checkOutput("jal_off.taken", {31'b0, branch_taken}, 32'h0);
`endif
    checkAll("jal");

    // Randomized operations against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [6:0]  op;
      logic [6:0]  f7;
      logic [31:0] a, b;
      op = OPS[$urandom_range(0, 10)];
      if (op == 7'h00) op = 7'($urandom);
      case ($urandom_range(0, 3))
        0:       f7 = 7'h20;
        1:       f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = {1'b1, 31'($urandom_range(0, 15))};
      applyStimulus(op, 3'($urandom), f7, a, b, $urandom);
      checkAll("rand");
    end

    // Reset mid-stream clears everything on the next edge
    @(negedge clk);
    rst = 1'b1;
    opcode = 7'b1100111; rs1 = 32'h4000; rs2 = 32'h10; pc = 32'h800;
    @(posedge clk); #1;
    checkResetState("midreset");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // Guard against a stalled simulation
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
